uart_rx_param: RTL and testbench

//  Parametrised serial frame receiver, successor to the fixed single-bit uart detector.

---
 rtl/uart_rx_param.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised serial frame receiver: idle-low line, high start bit, LSB-first data, low stop bit.
// Define UART_RX_PARITY_EN to insert and check a parity slot between the data bits and the stop bit.
module uart_rx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 signal,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CYC_START = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, RECOVER} state_t;

  state_t               state, state_d;
  logic [CW-1:0]        cyc, cyc_d;
  logic [BW-1:0]        bit_cnt, bit_d;
  logic [DATA_BITS-1:0] shreg, shreg_d, data_d;
  logic                 valid_d, frame_err_d;
  logic                 slot_end;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_TARGET = (PARITY_ODD != 0);
  logic par, par_d, parity_err_d;
`else
  // PARITY_ODD has no effect when there is no parity slot
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
  assign parity_err = 1'b0;
`endif

  // The cycle counter runs from the start edge across the whole start slot, so bit k lands at k*CLKS_PER_BIT.
  always_comb begin
    state_d     = state;
    cyc_d       = cyc;
    bit_d       = bit_cnt;
    shreg_d     = shreg;
    data_d      = data;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par;
    parity_err_d = 1'b0;
`endif
    slot_end = (cyc == CYC_LAST);
    unique case (state)
      IDLE: begin
        cyc_d = '0;
        bit_d = '0;
`ifdef UART_RX_PARITY_EN
        par_d = 1'b0;
`endif
        if (signal) state_d = (CLKS_PER_BIT == 1) ? DATA : START;
      end
      START: begin
        cyc_d = cyc + 1'b1;
        if (cyc == CYC_START) state_d = signal ? DATA : IDLE;
      end
      DATA: begin
        if (slot_end) begin
          cyc_d   = '0;
          shreg_d = (shreg >> 1) | (DATA_BITS'(signal) << (DATA_BITS - 1));
`ifdef UART_RX_PARITY_EN
          par_d = par ^ signal;
`endif
          if (bit_cnt == BIT_LAST) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_cnt + 1'b1;
          end
        end else begin
          cyc_d = cyc + 1'b1;
        end
      end
      PARITY: begin
        if (slot_end) begin
          cyc_d   = '0;
          state_d = STOP;
`ifdef UART_RX_PARITY_EN
          par_d = par ^ signal;
`endif
        end else begin
          cyc_d = cyc + 1'b1;
        end
      end
      STOP: begin
        if (slot_end) begin
          cyc_d = '0;
          if (signal) begin
            frame_err_d = 1'b1;
            state_d     = RECOVER;
          end
`ifdef UART_RX_PARITY_EN
          else if (par != PAR_TARGET) begin
            parity_err_d = 1'b1;
            state_d      = IDLE;
          end
`endif
          else begin
            valid_d = 1'b1;
            data_d  = shreg;
            state_d = IDLE;
          end
        end else begin
          cyc_d = cyc + 1'b1;
        end
      end
      RECOVER: begin
        if (!signal) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cyc       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par        <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      cyc       <= cyc_d;
      bit_cnt   <= bit_d;
      shreg     <= shreg_d;
      data      <= data_d;
      valid     <= valid_d;
      frame_err <= frame_err_d;
      busy      <= (state_d != IDLE);
`ifdef UART_RX_PARITY_EN
      par        <= par_d;
      parity_err <= parity_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: one receiver at 1 clock/bit and one at 4 clocks/bit, checked every cycle
// against per-cycle expectations derived from frame timing arithmetic.
module tb_uart_rx_param;

`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int MAXC = 1024;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       sig_a = 1'b0;
  logic       sig_b = 1'b0;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, ferr_a, ferr_b, perr_a, perr_b, busy_a, busy_b;

  uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(1), .PARITY_ODD(0)) u_dut_a (
    .clk(clk), .reset(reset), .signal(sig_a), .data(data_a), .valid(valid_a),
    .frame_err(ferr_a), .parity_err(perr_a), .busy(busy_a)
  );

  uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_ODD(0)) u_dut_b (
    .clk(clk), .reset(reset), .signal(sig_b), .data(data_b), .valid(valid_b),
    .frame_err(ferr_b), .parity_err(perr_b), .busy(busy_b)
  );

  always #10 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Expected outputs after each numbered posedge, filled in when a frame is scheduled
  bit         exp_valid [2][MAXC];
  logic [7:0] exp_vdata [2][MAXC];
  bit         exp_ferr  [2][MAXC];
  bit         exp_perr  [2][MAXC];
  bit         exp_busy  [2][MAXC];
  bit         exp_rst   [2][MAXC];
  logic [7:0] model_word [2] = '{8'h00, 8'h00};

  int checks = 0;
  int fails  = 0;
  int n_valid [2] = '{0, 0};
  int n_ferr  [2] = '{0, 0};
  int n_perr  [2] = '{0, 0};
  int last_vcyc [2] = '{0, 0};
  int prev_vcyc [2] = '{0, 0};

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, got, exp);
    end
  endtask

  task automatic checkDut(input int d, input logic [7:0] dat, input logic v, input logic fe,
                          input logic pe, input logic bz);
    if (exp_rst[d][cycle]) model_word[d] = 8'h00;
    if (exp_valid[d][cycle]) model_word[d] = exp_vdata[d][cycle];
    checkOutput($sformatf("valid[%0d]", d), {31'd0, v}, {31'd0, exp_valid[d][cycle]});
    checkOutput($sformatf("data[%0d]", d), {24'd0, dat}, {24'd0, model_word[d]});
    checkOutput($sformatf("frame_err[%0d]", d), {31'd0, fe}, {31'd0, exp_ferr[d][cycle]});
    checkOutput($sformatf("parity_err[%0d]", d), {31'd0, pe}, {31'd0, exp_perr[d][cycle]});
    checkOutput($sformatf("busy[%0d]", d), {31'd0, bz}, {31'd0, exp_busy[d][cycle]});
    if (v === 1'b1) begin
      n_valid[d]++;
      prev_vcyc[d] = last_vcyc[d];
      last_vcyc[d] = cycle;
    end
    if (fe === 1'b1) n_ferr[d]++;
    if (pe === 1'b1) n_perr[d]++;
  endtask

  always @(negedge clk) begin
    if (cycle >= 1 && cycle < MAXC) begin
      checkDut(0, data_a, valid_a, ferr_a, perr_a, busy_a);
      checkDut(1, data_b, valid_b, ferr_b, perr_b, busy_b);
    end
  end

  // One call drives one line level, sampled at the next posedge (edge number cycle+1)
  task automatic applyStimulus(input int d, input logic v);
    @(negedge clk);
    if (d == 0) sig_a = v;
    else        sig_b = v;
  endtask

  task automatic applyIdle(input int d, input int n);
    for (int i = 0; i < n; i++) applyStimulus(d, 1'b0);
  endtask

  // Start edge s; stop sampled at t = s + (bits-1)*c; after a bad stop the line stays high
  // for hold more cycles and the first low sample at r ends the busy window.
  task automatic sendFrame(input int d, input logic [7:0] word, input logic stop_v,
                           input logic par_flip, input int hold);
    int   c, s, t, r, nb;
    logic q [$];
    c = (d == 0) ? 1 : 4;
    q.push_back(1'b1);
    for (int i = 0; i < 8; i++) q.push_back(word[i]);
`ifdef UART_RX_PARITY_EN
    q.push_back((^word) ^ par_flip);
`endif
    q.push_back(stop_v);
    nb = q.size();
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < c; j++) begin
        applyStimulus(d, q[k]);
        if (k == 0 && j == 0) begin
          s = cycle + 1;
          t = s + (nb - 1) * c;
          r = stop_v ? t + c + hold : t;
          for (int e = s; e < r; e++) exp_busy[d][e] = 1'b1;
          if (stop_v) exp_ferr[d][t] = 1'b1;
          else if (par_flip) exp_perr[d][t] = 1'b1;
          else begin
            exp_valid[d][t] = 1'b1;
            exp_vdata[d][t] = word;
          end
        end
      end
    end
    if (stop_v) begin
      for (int h = 0; h < hold; h++) applyStimulus(d, 1'b1);
      applyStimulus(d, 1'b0);
    end
  endtask

  initial begin
    int         s;
    logic [7:0] w;

    // Reset held for two edges with the lines toggling
    for (int d = 0; d < 2; d++) begin
      exp_rst[d][1] = 1'b1;
      exp_rst[d][2] = 1'b1;
    end
    reset = 1'b0; sig_a = 1'b1; sig_b = 1'b1;
    @(negedge clk);
    sig_a = 1'b0; sig_b = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("rst_data", {24'd0, data_a}, 32'h0);
    checkOutput("rst_busy", {31'd0, busy_b}, 32'h0);
    applyIdle(0, 2);

    // Good frame 0xA5
    sendFrame(0, 8'hA5, 1'b0, 1'b0, 0);
    applyIdle(0, 3);
    checkOutput("a5_count", n_valid[0], 1);
    checkOutput("a5_data", {24'd0, data_a}, 32'hA5);

    // Bad stop, line held high, then frame 0x12
    sendFrame(0, 8'h3C, 1'b1, 1'b0, 3);
    checkOutput("ferr_count", n_ferr[0], 1);
    checkOutput("ferr_data_held", {24'd0, data_a}, 32'hA5);
    sendFrame(0, 8'h12, 1'b0, 1'b0, 0);
    applyIdle(0, 3);
    checkOutput("after_ferr_count", n_valid[0], 2);
    checkOutput("after_ferr_data", {24'd0, data_a}, 32'h12);

    // Back-to-back frames with no idle gap
    sendFrame(0, 8'h01, 1'b0, 1'b0, 0);
    sendFrame(0, 8'hFF, 1'b0, 1'b0, 0);
    applyIdle(0, 3);
    checkOutput("b2b_count", n_valid[0], 4);
    checkOutput("b2b_spacing", last_vcyc[0] - prev_vcyc[0], 10 + PB);
    checkOutput("b2b_data", {24'd0, data_a}, 32'hFF);

    // Reset pulse right after data bit 4 of a frame
    w = 8'h0B;
    applyStimulus(0, 1'b1);
    s = cycle + 1;
    for (int e = s; e <= s + 4; e++) exp_busy[0][e] = 1'b1;
    exp_rst[0][s + 5] = 1'b1;
    exp_rst[1][s + 5] = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(0, w[i]);
    applyStimulus(0, 1'b0);
    reset = 1'b0;
    applyStimulus(0, 1'b0);
    reset = 1'b1;
    checkOutput("midrst_busy", {31'd0, busy_a}, 32'h0);
    checkOutput("midrst_data", {24'd0, data_a}, 32'h0);
    applyIdle(0, 3);
    sendFrame(0, 8'h5A, 1'b0, 1'b0, 0);
    applyIdle(0, 3);
    checkOutput("midrst_count", n_valid[0], 5);
    checkOutput("midrst_next_data", {24'd0, data_a}, 32'h5A);

    // Four clocks per bit: one-cycle glitch, then a real frame
    applyStimulus(1, 1'b1);
    s = cycle + 1;
    exp_busy[1][s]     = 1'b1;
    exp_busy[1][s + 1] = 1'b1;
    applyStimulus(1, 1'b0);
    applyStimulus(1, 1'b0);
    applyStimulus(1, 1'b0);
    checkOutput("glitch_busy", {31'd0, busy_b}, 32'h0);
    checkOutput("glitch_nostrobe", n_valid[1], 0);
    applyIdle(1, 4);
    sendFrame(1, 8'h5A, 1'b0, 1'b0, 0);
    applyIdle(1, 6);
    checkOutput("slow_count", n_valid[1], 1);
    checkOutput("slow_data", {24'd0, data_b}, 32'h5A);

`ifdef UART_RX_PARITY_EN
    sendFrame(1, 8'h07, 1'b0, 1'b0, 0);
    applyIdle(1, 6);
    checkOutput("par_ok_count", n_valid[1], 2);
    checkOutput("par_ok_data", {24'd0, data_b}, 32'h07);
    sendFrame(1, 8'h07, 1'b0, 1'b1, 0);
    applyIdle(1, 6);
    checkOutput("par_bad_perr", n_perr[1], 1);
    checkOutput("par_bad_novalid", n_valid[1], 2);
`else
    checkOutput("no_parity_err", n_perr[0] + n_perr[1], 0);
`endif

    applyIdle(0, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
